// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory req/ready bus (master: imem_req/imem_addr out, imem_ready/imem_rdata in)
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with PC, imem req/ready fetch, one-word skid buffer and IF/ID latch (ports: clk, reset, stall, redirect, redirect_target, imem bus, ID_Instruction/ID_PC/ID_valid, PC)
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_target,
  fetch_stage_if.master        imem,
  output logic [31:0]          ID_Instruction,
  output logic [31:0]          ID_PC,
  output logic                 ID_valid,
  output logic [31:0]          PC
);
  localparam logic [1:0] FETCH = 2'd0, HOLD = 2'd1, DRAIN = 2'd2;
  logic [1:0]  r_state;
  logic        r_armed;
  logic [31:0] r_pc, r_drain_addr, r_buf, r_id_instr, r_id_pc;
  logic        r_id_valid;
  logic        w_req, w_ready;
  logic [31:0] w_addr, w_target;
  assign w_req    = !reset && r_armed && (r_state == FETCH || r_state == DRAIN);
  assign w_ready  = w_req && imem.imem_ready;
  assign w_addr   = r_state == DRAIN ? r_drain_addr : r_pc;
  assign w_target = redirect_target & ~32'h3;
  assign imem.imem_req  = w_req;
  assign imem.imem_addr = w_addr;
  assign ID_Instruction = r_id_instr;
  assign ID_PC          = r_id_pc;
  assign ID_valid       = r_id_valid;
  assign PC             = r_pc;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= FETCH;
      r_armed      <= 1'b0;
      r_pc         <= RESET_PC;
      r_drain_addr <= 32'h0;
      r_buf        <= 32'h0;
      r_id_instr   <= NOP_INSTR;
      r_id_pc      <= 32'h0;
      r_id_valid   <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (r_state > DRAIN) begin
        r_state    <= FETCH;
        r_id_instr <= NOP_INSTR;
        r_id_pc    <= 32'h0;
        r_id_valid <= 1'b0;
      end else if (redirect) begin
        r_pc         <= w_target;
        r_buf        <= 32'h0;
        r_id_instr   <= NOP_INSTR;
        r_id_pc      <= 32'h0;
        r_id_valid   <= 1'b0;
        r_state      <= (w_req && !w_ready) ? DRAIN : FETCH;
        r_drain_addr <= w_addr;
      end else if (r_state == FETCH) begin
        if (w_ready && stall) begin
          r_buf   <= imem.imem_rdata;
          r_state <= HOLD;
        end else if (w_ready) begin
          r_id_instr <= imem.imem_rdata;
          r_id_pc    <= r_pc;
          r_id_valid <= 1'b1;
          r_pc       <= r_pc + 32'd4;
        end
      end else if (r_state == HOLD) begin
        if (!stall) begin
          r_id_instr <= r_buf;
          r_id_pc    <= r_pc;
          r_id_valid <= 1'b1;
          r_pc       <= r_pc + 32'd4;
          r_state    <= FETCH;
        end
      end else if (w_ready) begin
        r_state <= FETCH;
      end
    end
  end
endmodule
